// File: rtl/nv_ram_rws_64x64_fifo_ctrl.sv
// nv_ram_rws_64x64_fifo_ctrl
//
// Valid/ready FIFO sequencer around one external RWS RAM. The RAM has a
// 1-cycle registered read address and a combinational data output. This
// block owns the write/read pointers, the occupancy count and the read
// prefetch. The RAM's registered read address doubles as the output holding
// stage, so no data flops live here.
//
// Ports:
//   clk, rst          core clock (shared with the RAM), synchronous active-high reset
//   wr_pvld/prdy/pd   producer side
//   rd_pvld/prdy/pd   consumer side; rd_pd is the RAM read data
//   ram_wa/we/di      RAM write port
//   ram_ra/re         RAM read address and read-address load enable
//   ram_dout          RAM read data, M[registered read address]
//   count             entries held (unfetched + output entry), 0..DEPTH
//   idle              count==0 and no push this cycle
module nv_ram_rws_64x64_fifo_ctrl #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned AW    = 6,
    parameter int unsigned DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic [AW-1:0]    ram_wa,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_di,
    output logic [AW-1:0]    ram_ra,
    output logic             ram_re,
    input  logic [WIDTH-1:0] ram_dout,
    output logic [AW:0]      count,
    output logic             idle
);

    localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    // Entries written to the RAM but not yet fetched into the output stage.
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic          out_vld_q, out_vld_d;
    logic          push;

    always_comb begin
        count   = ram_cnt_q + {{AW{1'b0}}, out_vld_q};
        // Depends on registered state only; a full FIFO never accepts
        // alongside a pop.
        wr_prdy = (count != DepthCnt);
        push    = wr_pvld & wr_prdy & ~rst;

        ram_we  = push;
        ram_wa  = wr_ptr_q;
        ram_di  = wr_pd;

        // ram_cnt_q excludes this cycle's write, so a same-cycle write is
        // never fetched.
        ram_re  = ~rst & (ram_cnt_q != '0) & (~out_vld_q | rd_prdy);
        ram_ra  = rd_ptr_q;

        rd_pvld = out_vld_q;
        rd_pd   = ram_dout;
        idle    = (count == '0) & ~push;

        wr_ptr_d  = wr_ptr_q + AW'(push);
        rd_ptr_d  = rd_ptr_q + AW'(ram_re);
        ram_cnt_d = ram_cnt_q + (AW+1)'(push) - (AW+1)'(ram_re);
        if (ram_re) begin
            out_vld_d = 1'b1;
        end else if (rd_prdy) begin
            out_vld_d = 1'b0;
        end else begin
            out_vld_d = out_vld_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            out_vld_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            out_vld_q <= out_vld_d;
        end
    end

endmodule
